decoder_scan: RTL and testbench

DECODER_SCAN -- requirements
Module: decoder_scan

---
 rtl/decoder_scan.sv | 106 ++++++++++
 tb/tb_decoder_scan.sv | 117 +++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// decoder_scan: registered active-low decoder with direct and auto-scan modes.
// Define DECODER_SCAN_BLANK_EN for a one-cycle all-high blank between scan steps.
module decoder_scan #(
   parameter int SEL_W = 3,
   parameter int DWELL_W = 8,
   localparam int N_OUT = 2**SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic               sel_load,
   input  logic [DWELL_W-1:0] dwell,
   output logic [N_OUT-1:0]   y_n,
   output logic [SEL_W-1:0]   cur_sel,
   output logic               wrap,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, DIRECT, SCAN, BLANK} state_t;
   state_t state;
   logic [DWELL_W-1:0] cnt;
   logic [SEL_W-1:0] nxt;
   logic last;
`ifdef DECODER_SCAN_BLANK_EN
   logic [SEL_W-1:0] pend;
   logic pend_wrap;
`endif
   assign nxt = cur_sel + 1'b1;
   assign last = &cur_sel;
   function automatic logic [N_OUT-1:0] dec(input logic [SEL_W-1:0] i);
      return ~(N_OUT'(1) << i);
   endfunction
   // cnt holds the cycles left in the current step after this one
   always_ff @(posedge clk) begin
      wrap <= 1'b0;
      if (rst) begin
         state <= IDLE;
         y_n <= '1;
         cur_sel <= '0;
         busy <= 1'b0;
         cnt <= '0;
`ifdef DECODER_SCAN_BLANK_EN
         pend <= '0;
         pend_wrap <= 1'b0;
`endif
      end else if (!en) begin
         state <= IDLE;
         y_n <= '1;
         busy <= 1'b0;
      end else if (!mode) begin
         state <= DIRECT;
         y_n <= dec(sel);
         cur_sel <= sel;
         busy <= 1'b0;
      end else begin
         busy <= 1'b1;
         if (state == IDLE || state == DIRECT) begin
            state <= SCAN;
            y_n <= dec('0);
            cur_sel <= '0;
            cnt <= dwell;
         end else if (sel_load) begin
`ifdef DECODER_SCAN_BLANK_EN
            if (state == SCAN) begin
               state <= BLANK;
               y_n <= '1;
               pend <= sel;
               pend_wrap <= 1'b0;
            end else begin
               state <= SCAN;
               y_n <= dec(sel);
               cur_sel <= sel;
               cnt <= dwell;
            end
`else
            y_n <= dec(sel);
            cur_sel <= sel;
            cnt <= dwell;
`endif
`ifdef DECODER_SCAN_BLANK_EN
         end else if (state == BLANK) begin
            state <= SCAN;
            y_n <= dec(pend);
            cur_sel <= pend;
            wrap <= pend_wrap;
            cnt <= dwell;
`endif
         end else if (|cnt) begin
            cnt <= cnt - 1'b1;
         end else begin
`ifdef DECODER_SCAN_BLANK_EN
            state <= BLANK;
            y_n <= '1;
            pend <= nxt;
            pend_wrap <= last;
`else
            y_n <= dec(nxt);
            cur_sel <= nxt;
            wrap <= last;
            cnt <= dwell;
`endif
         end
      end
   end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed scoreboard bench for decoder_scan (SEL_W=3, DWELL_W=8).
module tb_decoder_scan;
   logic clk = 1'b0, rst, en, mode, sel_load;
   logic [2:0] sel;
   logic [7:0] dwell;
   logic [7:0] y_n;
   logic [2:0] cur_sel;
   logic wrap, busy;
   int compared = 0, mismatched = 0;
`ifdef DECODER_SCAN_BLANK_EN
   localparam int BL = 1;
`else
   localparam int BL = 0;
`endif
   typedef struct {
      string tag;
      logic [7:0] y;
      logic [2:0] c;
      logic w;
      logic b;
   } exp_t;
   exp_t q[$];

   decoder_scan dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .sel_load(sel_load),
      .dwell(dwell), .y_n(y_n), .cur_sel(cur_sel), .wrap(wrap), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] oh(input int i);
      return ~(8'd1 << i);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [7:0] y, input logic [2:0] c, input logic w, input logic b);
      exp_t e;
      q.push_back('{tag, y, c, w, b});
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk({e.tag, ".y_n"}, y_n, e.y);
      chk({e.tag, ".cur_sel"}, 8'(cur_sel), 8'(e.c));
      chk({e.tag, ".wrap"}, 8'(wrap), 8'(e.w));
      chk({e.tag, ".busy"}, 8'(busy), 8'(e.b));
   endtask

   // Expected scan trace after entry from IDLE/DIRECT with constant dwell d
   task automatic scan_run(input string tag, input int d, input int n);
      for (int k = 0; k < n; k++) begin
         int p, s, ph;
         p = d + 1 + BL;
         s = k / p;
         ph = k % p;
         if (ph <= d) cyc(tag, oh(s % 8), 3'(s % 8), (s > 0 && s % 8 == 0 && ph == 0), 1'b1);
         else cyc({tag, "_blank"}, 8'hFF, 3'(s % 8), 1'b0, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 3'd0; sel_load = 1'b0; dwell = 8'd0;
      repeat (3) cyc("reset", 8'hFF, 3'd0, 1'b0, 1'b0);
      rst = 1'b0; mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         cyc("direct", oh(i), 3'(i), 1'b0, 1'b0);
      end
      en = 1'b0;
      cyc("en_off", 8'hFF, 3'd7, 1'b0, 1'b0);
      en = 1'b1; mode = 1'b1; dwell = 8'd2;
      scan_run("scan_wrap", 2, 8 * (3 + BL) + 2);
      mode = 1'b0; sel = 3'd2;
      cyc("to_direct", 8'hFB, 3'd2, 1'b0, 1'b0);
      mode = 1'b1; dwell = 8'd0;
      scan_run("scan_d0", 0, 7 * (1 + BL) + 1);
      sel = 3'd5; sel_load = 1'b1;
`ifdef DECODER_SCAN_BLANK_EN
      cyc("load_blank", 8'hFF, 3'd7, 1'b0, 1'b1);
      sel_load = 1'b0;
      cyc("load", oh(5), 3'd5, 1'b0, 1'b1);
      cyc("after_load_blank", 8'hFF, 3'd5, 1'b0, 1'b1);
`else
      cyc("load", oh(5), 3'd5, 1'b0, 1'b1);
      sel_load = 1'b0;
`endif
      cyc("after_load", oh(6), 3'd6, 1'b0, 1'b1);
      mode = 1'b0; sel = 3'd0;
      cyc("pre_d1", 8'hFE, 3'd0, 1'b0, 1'b0);
      mode = 1'b1; dwell = 8'd1;
      scan_run("scan_d1", 1, 8 * (2 + BL) + 1);
      mode = 1'b0;
      cyc("pre_mid", 8'hFE, 3'd0, 1'b0, 1'b0);
      mode = 1'b1; dwell = 8'd10;
      scan_run("scan_d10", 10, 3 * (11 + BL) + 1);
      mode = 1'b0; sel = 3'd6;
      cyc("mid_mode", 8'hBF, 3'd6, 1'b0, 1'b0);
      mode = 1'b1;
      cyc("rescan", 8'hFE, 3'd0, 1'b0, 1'b1);
      en = 1'b0;
      cyc("en_off_scan", 8'hFF, 3'd0, 1'b0, 1'b0);
      en = 1'b1; mode = 1'b0; sel = 3'd3; sel_load = 1'b1;
      cyc("direct_ld", 8'hF7, 3'd3, 1'b0, 1'b0);
      mode = 1'b1;
      cyc("scan_ld", 8'hFE, 3'd0, 1'b0, 1'b1);
      rst = 1'b1;
      repeat (2) cyc("rst_prio", 8'hFF, 3'd0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
